// File: rtl/mul_sequencer.sv
// -----------------------------------------------------------------------------
// mul_sequencer
//
// Iterative shift-and-add multiplier for the EX stage. A MUL instruction
// (alu_control == 4'd8) presented with valid_in while the sequencer is idle is
// captured and processed one multiplier bit per clock. The pipeline is held
// with stall until the product is ready. The low DATA_W bits of op_a*op_b are
// then presented on result, together with a one-cycle result_valid strobe.
//
// Optional build macro:
//   MUL_EARLY_TERM_EN - finish as soon as the remaining multiplier bits are
//                       all zero, instead of always iterating DATA_W times.
//                       The product is the same in both builds.
//
// Parameters:
//   DATA_W        operand and result width in bits (>= 2)
//
// Ports:
//   clk           in   rising-edge clock
//   arst          in   asynchronous active-high reset
//   valid_in      in   the instruction in EX is valid
//   alu_control   in   [3:0] ALU operation code, 4'd8 = MUL
//   flush         in   synchronous abort of the EX instruction
//   op_a          in   [DATA_W-1:0] multiplicand
//   op_b          in   [DATA_W-1:0] multiplier
//   stall         out  holds the pipeline while a multiply is in progress
//   result        out  [DATA_W-1:0] low DATA_W bits of op_a*op_b
//   result_valid  out  one-cycle strobe, result is final
// -----------------------------------------------------------------------------
module mul_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              valid_in,
  input  logic [3:0]        alu_control,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              stall,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  localparam int              CNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);
  localparam logic [3:0]      OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_acc;
  logic [DATA_W-1:0]  r_mcand;
  logic [DATA_W-1:0]  r_mplier;
  logic [CNT_W-1:0]   r_count;

  logic               w_start;
  logic               w_last;
  logic [DATA_W-1:0]  w_acc_sum;
  logic [DATA_W-1:0]  w_mplier_shr;

  // A start is only meaningful in IDLE; the state check is applied at the use
  // sites so that DONE and BUSY ignore new requests.
  assign w_start = valid_in & (alu_control == OP_MUL) & ~flush;

  // Partial-product accumulation; carries out of the top bit fall off, which
  // gives the modulo-2^DATA_W product for signed and unsigned operands alike.
  assign w_acc_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_shr = r_mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
  // Once no set multiplier bits remain, the accumulator is already final.
  assign w_last = (r_count == LAST) || (w_mplier_shr == '0);
`else
  assign w_last = (r_count == LAST);
`endif

  // Stall is combinational so the pipeline freezes in the same cycle the MUL
  // is accepted. Flush and reset override it immediately.
  assign stall = ~arst & ~flush &
                 (((r_state == IDLE) & w_start) | (r_state == BUSY));

  assign result_valid = ~flush & (r_state == DONE);
  assign result       = r_acc;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_acc    <= '0;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_count  <= '0;
            r_state  <= BUSY;
          end
        end

        BUSY: begin
          // A flush abandons the operation without touching the accumulator,
          // so result keeps the partial value it showed before the flush.
          if (flush) begin
            r_state <= IDLE;
          end else begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shr;
            r_count  <= r_count + 1'b1;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end

        DONE: begin
          // Single strobe cycle; any start request here is ignored and is
          // picked up again only once back in IDLE.
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              arst;
  logic              valid_in;
  logic [3:0]        alu_control;
  logic              flush;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              stall;
  logic [DATA_W-1:0] result;
  logic              result_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[9];

  mul_sequencer #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .arst         (arst),
    .valid_in     (valid_in),
    .alu_control  (alu_control),
    .flush        (flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .stall        (stall),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: number of BUSY cycles for a given multiplier.
  function automatic int exp_busy(input logic [31:0] b);
    int n;
    n = 1;
    for (int i = 0; i < DATA_W; i++)
      if (b[i]) n = i + 1;
`ifdef MUL_EARLY_TERM_EN
    return n;
`else
    return (n > 0) ? DATA_W : DATA_W;
`endif
  endfunction

  // Accept in cycle 0, stall through the BUSY window, strobe in the next
  // cycle, then hold. A start attempt is made during the strobe cycle.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name,
                        input bit wait_first);
    int nb;
    int bad_k;
    nb    = exp_busy(b);
    bad_k = -1;
    if (wait_first) @(negedge clk);
    valid_in = 1'b1; alu_control = 4'd8; flush = 1'b0; op_a = a; op_b = b;
    #1;
    chk({name, " accept stall"}, 32'(stall), 32'd1);
    chk({name, " accept result_valid"}, 32'(result_valid), 32'd0);
    for (int k = 1; k <= nb; k++) begin
      @(negedge clk);
      valid_in = 1'($urandom_range(0, 1));
      op_a = $urandom; op_b = $urandom;
      #1;
      if ((stall !== 1'b1 || result_valid !== 1'b0) && bad_k < 0) bad_k = k;
    end
    chk({name, " busy window first bad cycle"}, 32'(bad_k), 32'hFFFF_FFFF);
    @(negedge clk);
    valid_in = 1'b1; alu_control = 4'd8; op_a = $urandom; op_b = $urandom;
    #1;
    chk({name, " done stall"}, 32'(stall), 32'd0);
    chk({name, " done result_valid"}, 32'(result_valid), 32'd1);
    chk({name, " done result"}, result, exp);
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    chk({name, " after stall"}, 32'(stall), 32'd0);
    chk({name, " after result_valid"}, 32'(result_valid), 32'd0);
    chk({name, " after result hold"}, result, exp);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r10;
    logic [31:0] part;
    int          bad;

    tbl[0] = '{32'd7,          32'd6,          32'd42};
    tbl[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    tbl[2] = '{32'd9,          32'd3,          32'd27};
    tbl[3] = '{32'h1234_5678,  32'd0,          32'd0};
    tbl[4] = '{32'h8000_0000,  32'd2,          32'd0};
    tbl[5] = '{32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF};
    tbl[6] = '{32'h0000_FFFF,  32'h0000_FFFF,  32'hFFFE_0001};
    tbl[7] = '{32'h0001_0000,  32'h0001_0000,  32'd0};
    tbl[8] = '{32'd0,          32'hDEAD_BEEF,  32'd0};

    // Reset state, with a start request present on the inputs.
    arst = 1'b0; valid_in = 1'b1; alu_control = 4'd8; flush = 1'b0;
    op_a = 32'd7; op_b = 32'd6;
    #1 arst = 1'b1;
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset result", result, 32'd0);
    @(posedge clk);
    #1 arst = 1'b0;
    // The first edge after release accepts the MUL.
    do_mul(32'd7, 32'd6, 32'd42, "first_after_reset", 1'b1);

    foreach (tbl[i]) begin
      do_mul(tbl[i].a, tbl[i].b, tbl[i].r, $sformatf("tbl%0d", i), 1'b1);
    end

    // Non-MUL opcode and invalid MUL never start the sequencer.
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      valid_in = 1'b1; alu_control = 4'd2; op_a = $urandom; op_b = $urandom;
      #1;
      if (stall !== 1'b0 || result_valid !== 1'b0) bad++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      valid_in = 1'b0; alu_control = 4'd8;
      #1;
      if (stall !== 1'b0 || result_valid !== 1'b0) bad++;
    end
    chk("non-mul stall/strobe cycles", 32'(bad), 32'd0);
    chk("non-mul result hold", result, tbl[8].r);

    // Flush in cycle 10 of a multiply.
    a = 32'h0123_4567; b = 32'hFFFF_FFFF;
    part = a * 32'h0000_01FF;
    @(negedge clk);
    valid_in = 1'b1; alu_control = 4'd8; flush = 1'b0; op_a = a; op_b = b;
    #1;
    chk("flush accept stall", 32'(stall), 32'd1);
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      valid_in = 1'b0; op_a = $urandom; op_b = $urandom;
      #1;
      if (stall !== 1'b1) bad++;
    end
    chk("flush busy cycles 1-9", 32'(bad), 32'd0);
    @(negedge clk);
    flush = 1'b1; valid_in = 1'b1; alu_control = 4'd8;
    #1;
    chk("flush cycle10 stall", 32'(stall), 32'd0);
    chk("flush cycle10 result_valid", 32'(result_valid), 32'd0);
    chk("flush cycle10 partial result", result, part);
    r10 = result;
    @(negedge clk);
    flush = 1'b0; valid_in = 1'b1; alu_control = 4'd8; op_a = 32'd3; op_b = 32'd5;
    #1;
    chk("flush cycle11 idle accept stall", 32'(stall), 32'd1);
    chk("flush cycle11 result unchanged", result, r10);
    do_mul(32'd3, 32'd5, 32'd15, "after_flush", 1'b0);

    // Reset in cycle 5 of a multiply.
    @(negedge clk);
    valid_in = 1'b1; alu_control = 4'd8; op_a = 32'd7; op_b = 32'd6;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
    @(negedge clk);
    valid_in = 1'b1; alu_control = 4'd8;
    #1;
    chk("arst pre stall", 32'(stall), 32'd1);
    chk("arst pre partial result", result, 32'd42);
    arst = 1'b1;
    #1;
    chk("arst stall", 32'(stall), 32'd0);
    chk("arst result_valid", 32'(result_valid), 32'd0);
    chk("arst result", result, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 arst = 1'b0;
    do_mul(32'd3, 32'd5, 32'd15, "after_arst", 1'b1);

    // Random operands against plain modular arithmetic.
    for (int n = 0; n < 20; n++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      do_mul(a, b, a * b, $sformatf("rand%0d", n), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port arst  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have port valid_in  input  1  the instruction in EX is valid.
REQ-005 The block SHALL have port alu_control  input  4  ALU operation code; 4'd8 = MUL.
REQ-006 The block SHALL have port flush  input  1  synchronous abort of the EX instruction.
REQ-007 The block SHALL have port op_a  input  DATA_W  multiplicand.
REQ-008 The block SHALL have port op_b  input  DATA_W  multiplier.
REQ-009 The block SHALL have port stall  output  1  holds the pipeline while a multiply is in progress.
REQ-010 The block SHALL have port result  output  DATA_W  low DATA_W bits of op_a*op_b.
REQ-011 The block SHALL have port result_valid  output  1  one-cycle strobe; result is final.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, BUSY and DONE.
REQ-013 start SHALL be defined as valid_in & (alu_control==4'd8) & ~flush, evaluated in IDLE only.
REQ-014 In IDLE with start=1, the block SHALL load acc=0, mcand=op_a, mplier=op_b, count=0, and enter BUSY at the next edge.
REQ-015 stall SHALL be combinational: 1 when (IDLE & start) or BUSY, else 0.
REQ-016 Each BUSY cycle SHALL add mcand to acc when mplier[0]=1, shift mcand left by 1, shift mplier right by 1, and increment count.
REQ-017 BUSY SHALL move to DONE after the cycle in which count reaches DATA_W-1, giving DATA_W BUSY cycles.
REQ-018 The DONE state SHALL last one cycle with result_valid=1 and stall=0, then return to IDLE.
REQ-019 The block SHALL not accept a new start in DONE.
REQ-020 Latency SHALL be: accept at cycle 0, stall high for cycles 0..DATA_W, result_valid at cycle DATA_W+1.
REQ-021 Arithmetic SHALL be modulo 2^DATA_W, with carries beyond bit DATA_W-1 discarded; the low bits are identical for signed and unsigned operands.
REQ-022 result SHALL present acc, updating only in BUSY and holding its value in IDLE and DONE until the next accept.
REQ-023 flush=1 in any state SHALL force stall=0 and result_valid=0 combinationally and return the FSM to IDLE at the next edge, leaving result unchanged.
REQ-024 Operand changes during BUSY SHALL have no effect.
REQ-025 alu_control other than 4'd8, or valid_in=0, SHALL leave the block in IDLE with stall=0.

Reset
REQ-026 arst=1 SHALL immediately force state=IDLE, acc=0, mcand=0, mplier=0, count=0, stall=0, result=0 and result_valid=0.
REQ-027 arst asserted mid-multiply SHALL discard the operation, and no result_valid SHALL follow.
REQ-028 After arst deasserts, the block SHALL accept a start on the first clock edge.

Configuration
REQ-029 Macro MUL_EARLY_TERM_EN, when defined, SHALL make BUSY also move to DONE after any cycle whose post-shift mplier equals 0.
REQ-030 With MUL_EARLY_TERM_EN defined, the number of BUSY cycles SHALL be max(1, index of highest set bit of op_b + 1).
REQ-031 Without MUL_EARLY_TERM_EN, the block SHALL always have DATA_W BUSY cycles, and results SHALL be identical in both builds.

Verification
REQ-032 The bench SHALL cover: op_a=7, op_b=6, MUL for 1 cycle -> stall high 33 cycles, result_valid at cycle 33, result=42.
REQ-033 The bench SHALL cover: op_a=32'hFFFFFFFF, op_b=32'hFFFFFFFF -> result=32'h00000001.
REQ-034 The bench SHALL cover: alu_control=4'd2 with valid_in=1 -> stall=0 and no result_valid ever.
REQ-035 The bench SHALL cover: start MUL, then flush at cycle 10 -> stall=0 from cycle 10, FSM in IDLE at cycle 11, no result_valid, and result not updated.
REQ-036 The bench SHALL cover: start MUL, then arst at cycle 5 -> all outputs 0 immediately, then a new MUL 3*5 -> result=15.
REQ-037 The bench SHALL cover: with MUL_EARLY_TERM_EN defined, op_b=3, op_a=9 -> 2 BUSY cycles, result_valid at cycle 3, result=27; op_b=0 -> 1 BUSY cycle, result=0.
